tiny16_gpio: RTL
================

// Module: tiny16_gpio
// PURPOSE
// Parametrised GPIO port for the tiny16 core. It replaces the fixed IN[7:0]/OUT[7:0] pins with
// WIDTH bidirectional pins, per-pin direction, and a set/clear/toggle output path.
// Inputs pass through synchronisers and drive per-pin edge detection, with a sticky, maskable
// interrupt. Sits on the core's register bus beside the register file; pins go to the top level.
// PARAMETERS
// WIDTH        8  number of pins; also the register data width (1..16)
// SYNC_STAGES  2  input synchroniser depth (>=2)
// PORTS
// CLK         in   1      system clock, all logic on rising edge
// RST         in   1      synchronous reset, active-low
// ADDR        in   3      register word address
// WDATA       in   WIDTH  write data
// WE          in   1      write strobe, one transfer per cycle
// RE          in   1      read strobe
// RDATA       out  WIDTH  registered read data
// RVALID      out  1      pulses high the cycle RDATA is valid
// PIN_IN      in   WIDTH  asynchronous pad inputs
// PIN_OUT     out  WIDTH  pad output values (= DATA_OUT)
// PIN_OE      out  WIDTH  pad output enables (= DIR)
// IRQ         out  1      level interrupt, registered
// BEHAVIOUR
// Reset (RST=0 at a rising edge):
// - All registers, the sync chain and the edge history clear to 0.
// - RDATA=0, RVALID=0, IRQ=0, PIN_OUT=0, PIN_OE=0 (all pins are inputs).
// Register map (ADDR):
// - 0 IN: read-only, synchronised pin value. Output pins read back their pad level.
// - 1 OUT: R/W.
// - 2 DIR: R/W, 1 = output.
// - 3 IE: R/W, per-pin interrupt enable.
// - 4 POL: R/W, 0 = rising, 1 = falling.
// - 5 BOTH: R/W, 1 = both edges, overrides POL.
// - 6 STAT: R/W1C, sticky edge flags.
// - 7 TGL: write-only, OUT <= OUT ^ WDATA; reads return 0.
// - Writes to IN are ignored.
// Bus:
// - Write takes effect at the edge where WE=1.
// - Read: RE=1 at edge k -> RDATA/RVALID valid after edge k; RVALID drops next cycle unless RE is held.
// - RDATA holds its last value while RVALID=0.
// - WE and RE together on the same ADDR: the read returns the pre-write value.
// Sync/edge path:
// - Chain s[0..S-1] with S = SYNC_STAGES; s[0] samples PIN_IN; prev <= s[S-1].
// - rise = s[S-1] & ~prev; fall = ~s[S-1] & prev.
// - ev = DIR==0 & armed & (BOTH ? rise|fall : POL ? fall : rise).
// - STAT <= (STAT & ~clr) | ev. Set wins over a same-cycle W1C of the same bit.
// - IRQ <= |(STAT & IE), so a masked flag stays set and raises IRQ when IE is later set.
// - Latency: a new pin level first sampled at edge k sets STAT after edge k+S and IRQ after edge k+S+1.
// Arming:
// - Counter after reset release; armed=1 once S+1 edges have passed with RST=1.
// - Edges before arming are discarded, so no spurious flags from pins that are high at reset.
// Other rules:
// - Pins switched from output to input keep their history. A level change seen in the same cycle
//   as the DIR write can flag.
// - Reset mid-operation clears everything, including pending STAT and armed, on that edge.
// - Pins above WIDTH do not exist; ADDR is always fully decoded.
// TESTING
// 1 Reset: drive PIN_IN=8'hFF through reset and 4 cycles after
//   -> STAT=0, IRQ=0, PIN_OE=0, and read IN=8'hFF.
// 2 Output path: write DIR=8'h0F, OUT=8'hA5, then TGL=8'h03
//   -> PIN_OE=0F, PIN_OUT=A6, and read OUT=A6.
// 3 Rising IRQ: IE=8'h01, PIN_IN[0] 0->1 sampled at edge k
//   -> STAT=01 after k+2, IRQ=1 after k+3; write STAT=01 -> IRQ=0 two edges later.
// 4 Modes: POL=8'h02, BOTH=8'h04; pulse pins 1 and 2 high for 4 cycles
//   -> STAT[1] set on the fall only, STAT[2] set on both edges, STAT[0] clear.
// 5 Collision: W1C of STAT[0] in the same cycle an edge on pin 0 sets it -> STAT[0] remains 1.
// 6 Bus timing: RE with WE to OUT (old 8'h11, new 8'h22)
//   -> RDATA=11 with RVALID=1 one cycle later, and a next read gives 22.
// 7 Mid-run reset: RST low for one edge while IRQ=1
//   -> IRQ, STAT, OUT and DIR all 0 after that edge.

Source files
------------

// File: rtl/tiny16_gpio.sv
// Parametrised bidirectional GPIO port for the tiny16 register bus: per-pin direction,
// set/clear/toggle outputs, synchronised inputs with sticky, maskable edge interrupts.
module tiny16_gpio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       ADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             WE,
  input  logic             RE,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  input  logic [WIDTH-1:0] PIN_IN,
  output logic [WIDTH-1:0] PIN_OUT,
  output logic [WIDTH-1:0] PIN_OE,
  output logic             IRQ
);

  typedef enum logic [2:0] {
    A_IN   = 3'd0,
    A_OUT  = 3'd1,
    A_DIR  = 3'd2,
    A_IE   = 3'd3,
    A_POL  = 3'd4,
    A_BOTH = 3'd5,
    A_STAT = 3'd6,
    A_TGL  = 3'd7
  } reg_addr_e;

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [ARM_W-1:0] arm_cnt_q;
  logic [WIDTH-1:0] out_q, dir_q, ie_q, pol_q, both_q, stat_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             irq_q;

  reg_addr_e        addr_e;
  logic [WIDTH-1:0] synced, rise, fall, sel_edge, ev;
  logic [WIDTH-1:0] dir_nxt, stat_clr, rd_mux;
  logic             armed;

  assign addr_e   = reg_addr_e'(ADDR);
  assign synced   = sync_q[SYNC_STAGES-1];
  assign rise     = synced & ~prev_q;
  assign fall     = ~synced & prev_q;
  assign armed    = (arm_cnt_q == ARM_W'(SYNC_STAGES + 1));

  // The new direction gates detection, so an edge arriving with the switch to input can flag.
  assign dir_nxt  = (WE && addr_e == A_DIR) ? WDATA : dir_q;
  assign sel_edge = (both_q & (rise | fall)) | (~both_q & ((pol_q & fall) | (~pol_q & rise)));
  assign ev       = armed ? (~dir_nxt & sel_edge) : '0;
  assign stat_clr = (WE && addr_e == A_STAT) ? WDATA : '0;

  // NOTE: every output of an always_comb gets a default first, otherwise unlisted cases infer latches.
  always_comb begin
    rd_mux = '0;
    case (addr_e)
      A_IN:    rd_mux = synced;
      A_OUT:   rd_mux = out_q;
      A_DIR:   rd_mux = dir_q;
      A_IE:    rd_mux = ie_q;
      A_POL:   rd_mux = pol_q;
      A_BOTH:  rd_mux = both_q;
      A_STAT:  rd_mux = stat_q;
      default: rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      ie_q      <= '0;
      pol_q     <= '0;
      both_q    <= '0;
      stat_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sync_q[0] <= PIN_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= synced;
      if (!armed) arm_cnt_q <= arm_cnt_q + ARM_W'(1);

      // Set wins over a same-cycle clear of the same flag.
      stat_q <= (stat_q & ~stat_clr) | ev;
      irq_q  <= |(stat_q & ie_q);

      rvalid_q <= RE;
      if (RE) rdata_q <= rd_mux;

      dir_q <= dir_nxt;
      if (WE) begin
        case (addr_e)
          A_OUT:   out_q  <= WDATA;
          A_IE:    ie_q   <= WDATA;
          A_POL:   pol_q  <= WDATA;
          A_BOTH:  both_q <= WDATA;
          A_TGL:   out_q  <= out_q ^ WDATA;
          default: ;
        endcase
      end
    end
  end

  assign RDATA   = rdata_q;
  assign RVALID  = rvalid_q;
  assign PIN_OUT = out_q;
  assign PIN_OE  = dir_q;
  assign IRQ     = irq_q;

endmodule
